// File: rtl/trigger_window_match.sv
// Trigger matching: per trigger, frames hits whose coarse time lies in a (possibly
// wrapping) window as header / hit words / trailer through a single output slot.
module trigger_window_match #(
  parameter int WIDTH     = 12,
  parameter int CHNL_W    = 5,
  parameter int TRIG_ID_W = 12,
  parameter int MAX_HITS  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     rollover,
  input  logic [WIDTH-1:0]     trig_latency,
  input  logic [WIDTH-1:0]     match_window,
  input  logic [WIDTH-1:0]     coarse_time,
  input  logic                 trig_valid,
  output logic                 trig_ready,
  input  logic [WIDTH-1:0]     trig_time,
  input  logic                 hit_valid,
  output logic                 hit_ready,
  input  logic [WIDTH-1:0]     hit_time,
  input  logic [CHNL_W-1:0]    hit_chnl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_type,
  output logic [TRIG_ID_W-1:0] out_trig_id,
  output logic [CHNL_W-1:0]    out_chnl,
  output logic [WIDTH-1:0]     out_time,
  output logic [7:0]           out_count,
  output logic                 out_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_MATCH, S_TRAILER} state_t;

  localparam logic [1:0] T_HDR = 2'b00;
  localparam logic [1:0] T_HIT = 2'b01;
  localparam logic [1:0] T_TRL = 2'b10;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     start_q, start_d;
  logic [TRIG_ID_W-1:0] trig_id_q, trig_id_d;
  logic [7:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [1:0]           out_type_q, out_type_d;
  logic [TRIG_ID_W-1:0] out_trig_id_q, out_trig_id_d;
  logic [CHNL_W-1:0]    out_chnl_q, out_chnl_d;
  logic [WIDTH-1:0]     out_time_q, out_time_d;
  logic [7:0]           out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  // Distance a-b going forward around the rollover; rollover+1 may wrap to 0
  // at full counter width, which still yields the right modular result.
  function automatic logic [WIDTH-1:0] md(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a >= b) return a - b;
    return a - b + rollover + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [WIDTH:0]   half_w;
  logic [WIDTH-1:0] hit_d, to_d, start_new;
  logic             hit_in, hit_late, timeout, slot_free, out_fire, hit_fire;

  assign half_w    = ({1'b0, rollover} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
  assign start_new = md(trig_time, trig_latency);
  assign hit_d     = md(hit_time, start_q);
  assign to_d      = md(coarse_time, start_q);
  assign hit_in    = hit_d <= match_window;
  assign hit_late  = !hit_in && ({1'b0, hit_d} < half_w);
  assign timeout   = (to_d > match_window) && ({1'b0, to_d} < half_w);
  assign slot_free = !out_valid_q || out_ready;
  assign out_fire  = out_valid_q && out_ready;

  assign trig_ready = (state_q == S_IDLE);
  assign hit_ready  = (state_q == S_MATCH) && !hit_late && slot_free;
  assign hit_fire   = hit_valid && hit_ready;

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    trig_id_d     = trig_id_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    out_valid_d   = out_fire ? 1'b0 : out_valid_q;
    out_type_d    = out_type_q;
    out_trig_id_d = out_trig_id_q;
    out_chnl_d    = out_chnl_q;
    out_time_d    = out_time_q;
    out_count_d   = out_count_q;
    out_ovf_d     = out_ovf_q;
    case (state_q)
      S_IDLE: if (trig_valid) begin
        start_d       = start_new;
        out_valid_d   = 1'b1;
        out_type_d    = T_HDR;
        out_trig_id_d = trig_id_q;
        out_chnl_d    = '0;
        out_time_d    = trig_time;
        out_count_d   = '0;
        out_ovf_d     = 1'b0;
        state_d       = S_HEADER;
      end
      S_HEADER: if (out_fire) state_d = S_MATCH;
      S_MATCH: begin
        if (hit_fire) begin
          // early hits fall through here: consumed with nothing emitted
          if (hit_in) begin
            if (count_q < 8'(MAX_HITS)) begin
              out_valid_d   = 1'b1;
              out_type_d    = T_HIT;
              out_trig_id_d = trig_id_q;
              out_chnl_d    = hit_chnl;
              out_time_d    = hit_d;
              out_count_d   = '0;
              out_ovf_d     = 1'b0;
              count_d       = count_q + 8'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (slot_free && ((hit_valid && hit_late) || timeout)) begin
          // close only once the slot can take the trailer, so it lands next cycle
          out_valid_d   = 1'b1;
          out_type_d    = T_TRL;
          out_trig_id_d = trig_id_q;
          out_chnl_d    = '0;
          out_time_d    = '0;
          out_count_d   = count_q;
          out_ovf_d     = ovf_q;
          state_d       = S_TRAILER;
        end
      end
      S_TRAILER: if (out_fire) begin
        trig_id_d = trig_id_q + {{(TRIG_ID_W-1){1'b0}}, 1'b1};
        count_d   = '0;
        ovf_d     = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_q       <= '0;
      trig_id_q     <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_type_q    <= '0;
      out_trig_id_q <= '0;
      out_chnl_q    <= '0;
      out_time_q    <= '0;
      out_count_q   <= '0;
      out_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      trig_id_q     <= trig_id_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      out_valid_q   <= out_valid_d;
      out_type_q    <= out_type_d;
      out_trig_id_q <= out_trig_id_d;
      out_chnl_q    <= out_chnl_d;
      out_time_q    <= out_time_d;
      out_count_q   <= out_count_d;
      out_ovf_q     <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_type     = out_type_q;
  assign out_trig_id  = out_trig_id_q;
  assign out_chnl     = out_chnl_q;
  assign out_time     = out_time_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule
